// File: rtl/module_display_mux.sv
// Time-multiplexed 7-segment driver: double-buffered frame data, one blank cycle
// after every digit advance, and optional leading-zero suppression.
module module_display_mux #(
    parameter int N_DIGITS = 8
) (
    input  logic                    clk_10Mhz_i,
    input  logic                    reset_i,
    input  logic                    tick_i,
    input  logic [4*N_DIGITS-1:0]   data_i,
    input  logic [N_DIGITS-1:0]     dp_i,
    input  logic                    load_i,
    input  logic                    blank_lz_i,
    output logic [N_DIGITS-1:0]     an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int              IW       = $clog2(N_DIGITS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(N_DIGITS - 1);

    logic [IW-1:0]              idx;
    logic [4*N_DIGITS-1:0]      pend_data;
    logic [N_DIGITS-1:0]        pend_dp;
    logic                       pend_valid;
    logic [4*N_DIGITS-1:0]      disp_data;
    logic [N_DIGITS-1:0]        disp_dp;

    logic                       wrap;
    logic [3:0]                 cur_nib;
    logic                       cur_dp;
    logic [N_DIGITS-1:0]        cur_an;
    logic [N_DIGITS-1:0]        zero_above;
    logic                       cur_suppress;
    logic [6:0]                 cur_seg;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign wrap = tick_i && (idx == LAST_IDX);

    // zero_above[k] is set when displayed nibbles N_DIGITS-1 down to k are all zero.
    always_comb begin
        zero_above[N_DIGITS-1] = (disp_data[4*(N_DIGITS-1) +: 4] == 4'h0);
        for (int k = N_DIGITS - 2; k >= 0; k--) begin
            zero_above[k] = zero_above[k+1] && (disp_data[4*k +: 4] == 4'h0);
        end
    end

    always_comb begin
        cur_nib      = 4'h0;
        cur_dp       = 1'b0;
        cur_an       = '1;
        cur_suppress = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib      = disp_data[4*k +: 4];
                cur_dp       = disp_dp[k];
                cur_an[k]    = 1'b0;
                cur_suppress = blank_lz_i && (k != 0) && zero_above[k];
            end
        end
        cur_seg = decode(cur_nib);
    end

    always_ff @(posedge clk_10Mhz_i) begin
        if (reset_i) begin
            idx <= '0;
        end else if (tick_i) begin
            idx <= wrap ? '0 : idx + IW'(1);
        end
    end

    // Pending is read before it is overwritten, so a load on the wrap edge lands
    // in pending while the previous pending contents move to the display.
    always_ff @(posedge clk_10Mhz_i) begin
        if (reset_i) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            disp_data  <= '0;
            disp_dp    <= '0;
        end else begin
            if (wrap && pend_valid) begin
                disp_data  <= pend_data;
                disp_dp    <= pend_dp;
                pend_valid <= 1'b0;
            end
            if (load_i) begin
                pend_data  <= data_i;
                pend_dp    <= dp_i;
                pend_valid <= 1'b1;
            end
        end
    end

    // A tick blanks the next cycle; the new index shows from the cycle after.
    always_ff @(posedge clk_10Mhz_i) begin
        if (reset_i) begin
            an_o    <= '1;
            seg_o   <= 7'h7F;
            dp_o    <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            frame_o <= wrap;
            if (tick_i || cur_suppress) begin
                an_o  <= '1;
                seg_o <= 7'h7F;
                dp_o  <= 1'b1;
            end else begin
                an_o  <= cur_an;
                seg_o <= cur_seg;
                dp_o  <= ~cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_module_display_mux.sv
// Bench for module_display_mux (N_DIGITS=8): a cycle model feeds an expected queue
// checked every cycle, plus directed scenario checks.
module tb_module_display_mux;

    localparam int N = 8;

    logic           clk_10Mhz_i = 1'b0;
    logic           reset_i     = 1'b1;
    logic           tick_i      = 1'b0;
    logic [4*N-1:0] data_i      = '0;
    logic [N-1:0]   dp_i        = '0;
    logic           load_i      = 1'b0;
    logic           blank_lz_i  = 1'b0;
    logic [N-1:0]   an_o;
    logic [6:0]     seg_o;
    logic           dp_o;
    logic           frame_o;

    module_display_mux #(.N_DIGITS(N)) dut (
        .clk_10Mhz_i (clk_10Mhz_i),
        .reset_i     (reset_i),
        .tick_i      (tick_i),
        .data_i      (data_i),
        .dp_i        (dp_i),
        .load_i      (load_i),
        .blank_lz_i  (blank_lz_i),
        .an_o        (an_o),
        .seg_o       (seg_o),
        .dp_o        (dp_o),
        .frame_o     (frame_o)
    );

    always #50 clk_10Mhz_i = ~clk_10Mhz_i;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q[$];
    logic [6:0]  seg_tbl[16];

    int          m_idx;
    logic [31:0] m_disp, m_pend;
    logic [7:0]  m_ddp, m_pdp;
    logic        m_pv;

    // Scoreboard: entry is {frame, dp, seg, an} expected after each clock edge.
    always @(posedge clk_10Mhz_i) begin
        logic [16:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({frame_o, dp_o, seg_o, an_o} !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got frame=%b dp=%b seg=%h an=%h exp frame=%b dp=%b seg=%h an=%h",
                         $time, frame_o, dp_o, seg_o, an_o, e[16], e[15], e[14:8], e[7:0]);
            end
        end
    end

    task automatic cyc(input logic rst, input logic tk, input logic ld,
                       input logic [31:0] d, input logic [7:0] p);
        logic [16:0] e;
        logic [3:0]  nib;
        reset_i = rst;
        tick_i  = tk;
        load_i  = ld;
        data_i  = d;
        dp_i    = p;
        if (rst) begin
            e = {1'b0, 1'b1, 7'h7F, 8'hFF};
        end else begin
            e[16] = tk && (m_idx == N - 1);
            if (tk || (blank_lz_i && m_idx > 0 && (m_disp >> (4 * m_idx)) == 32'h0)) begin
                e[15:0] = {1'b1, 7'h7F, 8'hFF};
            end else begin
                nib     = m_disp[4*m_idx +: 4];
                e[15:0] = {~m_ddp[m_idx], seg_tbl[nib], ~(8'h01 << m_idx)};
            end
        end
        exp_q.push_back(e);
        if (rst) begin
            m_idx = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pv = 1'b0;
        end else begin
            if (tk) begin
                if (m_idx == N - 1 && m_pv) begin
                    m_disp = m_pend;
                    m_ddp  = m_pdp;
                    m_pv   = 1'b0;
                end
                m_idx = (m_idx + 1) % N;
            end
            if (ld) begin
                m_pend = d;
                m_pdp  = p;
                m_pv   = 1'b1;
            end
        end
        @(posedge clk_10Mhz_i);
        #2;
    endtask

    // data_i/dp_i carry random junk whenever load_i is low.
    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, $urandom, 8'($urandom));
    endtask

    task automatic tick();
        cyc(1'b0, 1'b1, 1'b0, $urandom, 8'($urandom));
    endtask

    task automatic go_to(input int t);
        while (m_idx != t) begin
            tick();
            idle();
        end
    endtask

    task automatic new_frame();
        do begin
            tick();
            idle();
        end while (m_idx != 0);
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 8'hFF);
        cyc(1'b1, 1'b1, 1'b1, 32'h1234_5678, 8'hFF);
        checks++;
        if ({an_o, seg_o, dp_o, frame_o} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got an=%h seg=%h dp=%b frame=%b exp an=ff seg=7f dp=1 frame=0",
                     an_o, seg_o, dp_o, frame_o);
        end
        idle();
        checks++;
        if ({an_o, seg_o, dp_o} !== {8'hFE, 7'h40, 1'b1}) begin
            errors++;
            $display("FAIL after_reset got an=%h seg=%h dp=%b exp an=fe seg=40 dp=1", an_o, seg_o, dp_o);
        end
    endtask

    task automatic test_load_wrap();
        logic [6:0] exp_seg[4];
        int fr;
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        fr = 0;
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_1234, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (frame_o) fr++;
            if (i == 7) begin
                checks++;
                if (frame_o !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_at_wrap got %b exp 1", frame_o);
                end
            end
            idle();
            if (frame_o) fr++;
            if (i < 7) begin
                checks++;
                if (seg_o !== 7'h40) begin
                    errors++;
                    $display("FAIL no_early_update digit=%0d got seg=%h exp 40", i + 1, seg_o);
                end
            end
        end
        checks++;
        if (fr != 1) begin
            errors++;
            $display("FAIL frame_count got %0d exp 1", fr);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({an_o, seg_o} !== {~(8'h01 << k), exp_seg[k]}) begin
                errors++;
                $display("FAIL digit_decode k=%0d got an=%h seg=%h exp an=%h seg=%h",
                         k, an_o, seg_o, ~(8'h01 << k), exp_seg[k]);
            end
            tick();
            idle();
        end
    endtask

    task automatic test_back_to_back();
        int s;
        s = m_idx;
        tick();
        checks++;
        if (an_o !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_blank1 got an=%h exp ff", an_o);
        end
        tick();
        checks++;
        if (an_o !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_blank2 got an=%h exp ff", an_o);
        end
        idle();
        checks++;
        if (an_o !== ~(8'h01 << ((s + 2) % N))) begin
            errors++;
            $display("FAIL b2b_advance got an=%h exp %h", an_o, ~(8'h01 << ((s + 2) % N)));
        end
    endtask

    task automatic test_blank_lz();
        logic [6:0] es;
        logic [7:0] ea;
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0050, 8'h00);
        new_frame();
        for (int pass = 0; pass < 2; pass++) begin
            blank_lz_i = (pass == 0);
            for (int k = 0; k < N; k++) begin
                if (k == 0)      begin ea = 8'hFE; es = 7'h40; end
                else if (k == 1) begin ea = 8'hFD; es = 7'h12; end
                else if (pass == 0) begin ea = 8'hFF; es = 7'h7F; end
                else             begin ea = ~(8'h01 << k); es = 7'h40; end
                if (k == 0 && pass == 0) idle();
                checks++;
                if ({an_o, seg_o} !== {ea, es}) begin
                    errors++;
                    $display("FAIL blank_lz lz=%b k=%0d got an=%h seg=%h exp an=%h seg=%h",
                             blank_lz_i, k, an_o, seg_o, ea, es);
                end
                tick();
                idle();
            end
        end
        go_to(3);
        blank_lz_i = 1'b1;
        idle();
        checks++;
        if ({an_o, seg_o} !== {8'hFF, 7'h7F}) begin
            errors++;
            $display("FAIL lz_immediate got an=%h seg=%h exp an=ff seg=7f", an_o, seg_o);
        end
        blank_lz_i = 1'b0;
        idle();
    endtask

    task automatic test_load_on_wrap();
        go_to(3);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_000A, 8'h00);
        go_to(7);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_000B, 8'h00);
        idle();
        checks++;
        if ({an_o, seg_o} !== {8'hFE, 7'h08}) begin
            errors++;
            $display("FAIL wrap_load_A got an=%h seg=%h exp an=fe seg=08", an_o, seg_o);
        end
        new_frame();
        checks++;
        if ({an_o, seg_o} !== {8'hFE, 7'h03}) begin
            errors++;
            $display("FAIL wrap_load_B got an=%h seg=%h exp an=fe seg=03", an_o, seg_o);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b0, 1'b0, 1'b1, 32'h8765_4321, 8'hFF);
        go_to(5);
        cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 8'hFF);
        checks++;
        if ({an_o, seg_o, dp_o, frame_o} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midreset got an=%h seg=%h dp=%b frame=%b exp an=ff seg=7f dp=1 frame=0",
                     an_o, seg_o, dp_o, frame_o);
        end
        idle();
        new_frame();
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({an_o, seg_o, dp_o} !== {~(8'h01 << k), 7'h40, 1'b1}) begin
                errors++;
                $display("FAIL midreset_zero k=%0d got an=%h seg=%h dp=%b exp seg=40 dp=1",
                         k, an_o, seg_o, dp_o);
            end
            tick();
            idle();
        end
    endtask

    task automatic test_dp();
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0000, 8'h04);
        new_frame();
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({an_o, dp_o} !== {~(8'h01 << k), (k != 2)}) begin
                errors++;
                $display("FAIL dp k=%0d got an=%h dp=%b exp an=%h dp=%b",
                         k, an_o, dp_o, ~(8'h01 << k), (k != 2));
            end
            tick();
            idle();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) blank_lz_i = ~blank_lz_i;
            cyc($urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 255)) : $urandom,
                8'($urandom));
        end
    endtask

    initial begin
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        m_idx = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pv = 1'b0;
        test_reset();
        test_load_wrap();
        test_back_to_back();
        test_blank_lz();
        test_load_on_wrap();
        test_reset_mid();
        test_dp();
        test_random();
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
